// File: rtl/i2c_sensor_responder.sv
// I2C target that mirrors register writes as wr_vld/wr_addr/wr_data pulses.
// Define I2C_RESP_READBACK_EN to add the mirror memory and the read path.
module i2c_sensor_responder #(
  parameter logic [6:0] I2C_SLAVE_ADDR = 7'd16,
  parameter int         MEM_AW         = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_vld,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

`ifdef I2C_RESP_READBACK_EN
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;
  localparam bit READ_OK = 1'b1;
`else
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK,
    WR_DATA, WR_ACK
  } state_t;
  localparam bit READ_OK = 1'b0;
`endif

  state_t      state;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic        rx_state, rx_done, addr_ok;
  logic [2:0]  bit_cnt;
  logic [6:0]  sreg;
  logic [7:0]  byte_in;
  logic [7:0]  reg_hi;
  logic [15:0] ptr;
  logic        ack_phase;

`ifdef I2C_RESP_READBACK_EN
  logic        rw;
  logic [7:0]  rd_sreg;
  logic [7:0]  rd_byte;
  logic [7:0]  mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_addr[MEM_AW-1:0]] <= wr_data;
  end

  assign rd_byte = mem[ptr[MEM_AW-1:0]];
`else
  // MEM_AW only sizes the mirror memory, which this build leaves out.
  logic unused_mem_aw;
  assign unused_mem_aw = ^MEM_AW;
`endif

  // Stage p0/p1: synchronizer, stage p2: edge-detect history (bus idle = 1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  always_comb begin
    scl_rise  = scl_p1 & ~scl_p2;
    scl_fall  = ~scl_p1 & scl_p2;
    start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
    byte_in   = {sreg, sda_p1};
    rx_state  = (state == DEV_ADDR) || (state == REG_HI) ||
                (state == REG_LO)   || (state == WR_DATA);
    rx_done   = rx_state && scl_rise && (bit_cnt == 3'd7);
    addr_ok   = (byte_in[7:1] == I2C_SLAVE_ADDR) && (READ_OK || !byte_in[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      wr_vld    <= 1'b0;
      wr_addr   <= 16'h0000;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      ptr       <= 16'h0000;
      bit_cnt   <= 3'd0;
      ack_phase <= 1'b0;
    end else begin
      wr_vld <= 1'b0;
      if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        // Pointer is kept so a repeated START can turn into a random read.
        state     <= DEV_ADDR;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DEV_ADDR: begin
            if (rx_done) begin
              if (addr_ok) begin
                state <= DEV_ACK;
                busy  <= 1'b1;
`ifdef I2C_RESP_READBACK_EN
                rw    <= byte_in[0];
`endif
              end else begin
                state <= IDLE;
              end
            end
          end
          REG_HI: begin
            if (rx_done) begin
              reg_hi <= byte_in;
              state  <= REG_HI_ACK;
            end
          end
          REG_LO: begin
            if (rx_done) begin
              ptr   <= {reg_hi, byte_in};
              state <= REG_LO_ACK;
            end
          end
          WR_DATA: begin
            if (rx_done) begin
              wr_vld  <= 1'b1;
              wr_addr <= ptr;
              wr_data <= byte_in;
              ptr     <= ptr + 16'd1;
              state   <= WR_ACK;
            end
          end
          // First SCL fall after the 8th bit pulls SDA, the next one releases it.
          DEV_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
`ifdef I2C_RESP_READBACK_EN
                if (rw) begin
                  state   <= RD_DATA;
                  sda_oe  <= ~rd_byte[7];
                  rd_sreg <= {rd_byte[6:0], 1'b0};
                end else begin
                  state  <= REG_HI;
                  sda_oe <= 1'b0;
                end
`else
                state  <= REG_HI;
                sda_oe <= 1'b0;
`endif
              end
            end
          end
          REG_HI_ACK, REG_LO_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                state     <= (state == REG_HI_ACK) ? REG_LO : WR_DATA;
              end
            end
          end
`ifdef I2C_RESP_READBACK_EN
          RD_DATA: begin
            if (scl_fall) begin
              sda_oe  <= ~rd_sreg[7];
              rd_sreg <= {rd_sreg[6:0], 1'b0};
            end
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RD_ACK;
            end
          end
          RD_ACK: begin
            if (scl_fall && !ack_phase) begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b1;
            end else if (scl_rise && ack_phase) begin
              if (sda_p1) begin
                state     <= IDLE;
                ack_phase <= 1'b0;
              end else begin
                ptr <= ptr + 16'd1;
              end
            end else if (scl_fall && ack_phase) begin
              // Pointer already advanced on the initiator's ACK.
              state     <= RD_DATA;
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd0;
              sda_oe    <= ~rd_byte[7];
              rd_sreg   <= {rd_byte[6:0], 1'b0};
            end
          end
`endif
          default: state <= IDLE;
        endcase
        if (rx_state && scl_rise) begin
          sreg    <= byte_in[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (rx_state && scl_fall) sda_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Directed bench for i2c_sensor_responder: vector table of write transactions
// plus hand sequences for aborts, reset during ACK and the read-address cases.
module tb_i2c_sensor_responder;
  localparam int Q = 5;
  localparam int H = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe, wr_vld, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int errors = 0;
  int checks = 0;

  int          n_pulse = 0;
  int          oe_cycles = 0;
  logic [15:0] cap_addr [0:63];
  logic [7:0]  cap_data [0:63];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_sensor_responder #(.I2C_SLAVE_ADDR(7'd16), .MEM_AW(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_vld  (wr_vld),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always @(negedge clk) begin
    if (wr_vld) begin
      cap_addr[n_pulse[5:0]] <= wr_addr;
      cap_data[n_pulse[5:0]] <= wr_data;
      n_pulse <= n_pulse + 1;
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wt(Q);
    scl = 1'b1;   wt(H);
    sda_m = 1'b0; wt(H);
    scl = 1'b0;   wt(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wt(Q);
    scl = 1'b1;   wt(H);
    sda_m = 1'b1; wt(H);
  endtask

  task automatic clk_bit(input logic b, output logic smp);
    sda_m = b;  wt(Q);
    scl = 1'b1; wt(Q);
    smp = sda_line;
    wt(Q);
    scl = 1'b0; wt(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [15:0] rg;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        ack;
    logic [15:0] a0;
    logic [15:0] a1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic       ack, s;
    logic [7:0] rb, pat;
    int         base_p, base_oe, idx;

    vecs[0] = '{8'h20, 16'h0160, 2, 8'h0D, 8'hE7, 1'b1, 16'h0160, 16'h0161};
    vecs[1] = '{8'h22, 16'h0000, 1, 8'h55, 8'h00, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{8'h20, 16'hFFFF, 2, 8'hA5, 8'h5A, 1'b1, 16'hFFFF, 16'h0000};
    vecs[3] = '{8'h20, 16'h1234, 1, 8'h3C, 8'h00, 1'b1, 16'h1234, 16'h0000};
    vecs[4] = '{8'h30, 16'h0001, 1, 8'h77, 8'h00, 1'b0, 16'h0000, 16'h0000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_wr_vld", wr_vld, 1'b0);
    check("rst_wr_addr", wr_addr, 16'h0000);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wt(H);

    for (int v = 0; v < 5; v++) begin
      base_p  = n_pulse;
      base_oe = oe_cycles;
      bus_start();
      send_byte(vecs[v].dev, ack);
      check($sformatf("v%0d_addr_ack", v), ack, vecs[v].ack);
      if (vecs[v].ack) begin
        check($sformatf("v%0d_busy", v), busy, 1'b1);
        send_byte(vecs[v].rg[15:8], ack);
        check($sformatf("v%0d_reghi_ack", v), ack, 1'b1);
        send_byte(vecs[v].rg[7:0], ack);
        check($sformatf("v%0d_reglo_ack", v), ack, 1'b1);
        send_byte(vecs[v].d0, ack);
        check($sformatf("v%0d_d0_ack", v), ack, 1'b1);
        if (vecs[v].n == 2) begin
          send_byte(vecs[v].d1, ack);
          check($sformatf("v%0d_d1_ack", v), ack, 1'b1);
        end
      end
      bus_stop();
      check($sformatf("v%0d_busy_stop", v), busy, 1'b0);
      check($sformatf("v%0d_pulses", v), n_pulse - base_p, vecs[v].ack ? vecs[v].n : 0);
      if (vecs[v].ack) begin
        check($sformatf("v%0d_addr0", v), cap_addr[base_p[5:0]], vecs[v].a0);
        check($sformatf("v%0d_data0", v), cap_data[base_p[5:0]], vecs[v].d0);
        if (vecs[v].n == 2) begin
          idx = base_p + 1;
          check($sformatf("v%0d_addr1", v), cap_addr[idx[5:0]], vecs[v].a1);
          check($sformatf("v%0d_data1", v), cap_data[idx[5:0]], vecs[v].d1);
        end
      end else begin
        check($sformatf("v%0d_oe_quiet", v), oe_cycles - base_oe, 0);
      end
    end

    // STOP four bits into a data byte
    base_p = n_pulse;
    pat = 8'hC3;
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h00, ack);
    send_byte(8'h40, ack);
    for (int i = 7; i >= 4; i--) clk_bit(pat[i], s);
    bus_stop();
    check("stop_abort_pulses", n_pulse - base_p, 0);
    check("stop_abort_busy", busy, 1'b0);

    // Repeated START four bits into a data byte, then a clean write
    base_p = n_pulse;
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h00, ack);
    send_byte(8'h50, ack);
    for (int i = 7; i >= 4; i--) clk_bit(pat[i], s);
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h00, ack);
    send_byte(8'h51, ack);
    send_byte(8'h99, ack);
    bus_stop();
    check("rs_abort_pulses", n_pulse - base_p, 1);
    check("rs_abort_addr", cap_addr[base_p[5:0]], 16'h0051);
    check("rs_abort_data", cap_data[base_p[5:0]], 8'h99);

    // Reset while the address ACK is being driven
    base_p = n_pulse;
    pat = 8'h20;
    bus_start();
    for (int i = 7; i >= 0; i--) clk_bit(pat[i], s);
    check("ack_driven", sda_oe, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_sda_oe", sda_oe, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    base_oe = oe_cycles;
    clk_bit(1'b1, s);
    check("rst_mid_9th_released", s, 1'b1);
    send_byte(8'h00, ack);
    check("rst_mid_ignored_ack", ack, 1'b0);
    send_byte(8'h10, ack);
    send_byte(8'hAA, ack);
    bus_stop();
    check("rst_mid_pulses", n_pulse - base_p, 0);
    check("rst_mid_oe_quiet", oe_cycles - base_oe, 0);

`ifndef I2C_RESP_READBACK_EN
    // Read request without the readback path
    base_oe = oe_cycles;
    bus_start();
    send_byte(8'h21, ack);
    check("rd_addr_nack", ack, 1'b0);
    check("rd_addr_busy", busy, 1'b0);
    send_byte(8'h00, ack);
    check("rd_addr_idle_silent", ack, 1'b0);
    bus_stop();
    check("rd_addr_oe_quiet", oe_cycles - base_oe, 0);
`else
    // Random read: pointer write, repeated START, two bytes
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h01, ack);
    send_byte(8'h60, ack);
    send_byte(8'h0D, ack);
    bus_stop();
    bus_start();
    send_byte(8'h20, ack);
    send_byte(8'h01, ack);
    send_byte(8'h60, ack);
    bus_start();
    send_byte(8'h21, ack);
    check("rd_addr_ack", ack, 1'b1);
    recv_byte(1'b1, rb);
    check("rd_byte0", rb, 8'h0D);
    recv_byte(1'b0, rb);
    check("rd_byte1", rb, 8'hE7);
    wt(Q);
    check("rd_nack_released", sda_oe, 1'b0);
    base_oe = oe_cycles;
    send_byte(8'hFF, ack);
    check("rd_nack_idle", oe_cycles - base_oe, 0);
    bus_stop();
    check("rd_busy_stop", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
